// File: rtl/sampler_defs.sv
// Shared definitions for the sample loader: widths, default sizes and the
// writer FSM state encoding.
package sampler_defs;

  localparam int SAMPLE_W   = 16;
  localparam int FIFO_DEPTH = 512;
  localparam int ADDR_W     = 19;
  localparam int MAX_FILES  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } writer_state_t;

  typedef struct packed {
    logic                new_file;
    logic [SAMPLE_W-1:0] sample;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; pushes into a full
// FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 512,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // define which entries are valid, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_loader.sv
// Drains the SD sample stream through a request FIFO into sample RAM and
// keeps a start/length table for each file marked by new_file.
module sample_loader #(
  parameter int FIFO_DEPTH = sampler_defs::FIFO_DEPTH,
  parameter int ADDR_W     = sampler_defs::ADDR_W,
  parameter int MAX_FILES  = sampler_defs::MAX_FILES,
  parameter int FILE_W     = $clog2(MAX_FILES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_available,
  input  logic signed [15:0]            sd_read_out,
  input  logic                          new_file,
  input  logic                          initial_load_finished,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] req_count,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [15:0]                   mem_din,
  input  logic                          mem_ready,
  input  logic [FILE_W-1:0]             file_sel,
  output logic [ADDR_W-1:0]             file_start,
  output logic [ADDR_W-1:0]             file_len,
  output logic [FILE_W:0]               num_files,
  output logic                          load_done,
  output logic                          overflow
);

  import sampler_defs::*;

  localparam logic [FILE_W:0] MAX_NF = (FILE_W + 1)'(MAX_FILES);

  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] len;
  } file_entry_t;

  writer_state_t     state, state_next;
  fifo_entry_t       head;
  logic              push, pop, fifo_empty, fifo_full;
  logic              open_file, enter_done, accept, start_discard, drop_sample;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       hold_sample;
  logic [FILE_W:0]   nf;
  logic [FILE_W-1:0] cur_idx;
  logic              discard, ram_full, ovf, done;
  file_entry_t       file_table [MAX_FILES];

  // Nothing is accepted once the load has completed.
  assign push = req_available && (state != ST_DONE);

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({new_file, sd_read_out}),
    .pop       (pop),
    .pop_data  (head),
    .count     (req_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    open_file     = 1'b0;
    enter_done    = 1'b0;
    accept        = 1'b0;
    start_discard = 1'b0;
    drop_sample   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_LOAD;
        end else if (initial_load_finished) begin
          state_next = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_LOAD: begin
        pop        = 1'b1;
        state_next = ST_IDLE;
        if (discard || ram_full) begin
          drop_sample = 1'b1;
        end else if (head.new_file) begin
          if (nf < MAX_NF) begin
            open_file  = 1'b1;
            state_next = ST_WRITE;
          end else begin
            start_discard = 1'b1;
            drop_sample   = 1'b1;
          end
        end else if (nf != '0) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          accept     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_DONE;
    endcase
  end

  assign cur_idx = nf[FILE_W-1:0] - FILE_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr     <= '0;
      hold_sample <= '0;
      nf          <= '0;
      discard     <= 1'b0;
      ram_full    <= 1'b0;
      ovf         <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < MAX_FILES; i++) file_table[i] <= '0;
    end else begin
      if (pop) hold_sample <= head.sample;
      // Opening a file or finishing the load closes whichever file is open.
      if ((open_file || enter_done) && nf != '0)
        file_table[cur_idx].len <= wr_addr - file_table[cur_idx].start;
      if (open_file) begin
        file_table[nf[FILE_W-1:0]].start <= wr_addr;
        nf <= nf + (FILE_W + 1)'(1);
      end
      if (accept) begin
        if (wr_addr == '1) ram_full <= 1'b1;
        else               wr_addr  <= wr_addr + ADDR_W'(1);
      end
      if (start_discard) discard <= 1'b1;
      if (drop_sample || (push && fifo_full)) ovf <= 1'b1;
      if (enter_done) done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      file_start <= '0;
      file_len   <= '0;
    end else begin
      file_start <= file_table[file_sel].start;
      file_len   <= file_table[file_sel].len;
    end
  end

  assign mem_wr_en = (state == ST_WRITE);
  assign mem_addr  = wr_addr;
  assign mem_din   = hold_sample;
  assign num_files = nf;
  assign load_done = done;
  assign overflow  = ovf;

endmodule
